md5_resp_tx: RTL

- Responder end of the host command protocol. `cmd_parser` and `string_process_match` consume host requests; this block serializes the search result back to the host as a framed response packet.
- Byte transport uses the existing `txd_start`/`txd_busy`/`txd_data` handshake of `async_transmitter`.
- Matched message characters are pulled from the matcher with a `match_char_next` strobe.
- Sits in `top_md5` between `string_process_match` result outputs and `async_transmitter`, on `clk_96mhz`.

---
 rtl/md5_proto_pkg.sv | 19 +
 rtl/md5_resp_tx.sv | 139 +++++++++++++
 2 files changed

// File: rtl/md5_proto_pkg.sv
// Shared constants and state encoding for the host response protocol.
// Status bytes lead every response packet; the header is status + 16-bit position.
package md5_proto_pkg;

    localparam logic [7:0] RESP_MATCH   = 8'h4D;
    localparam logic [7:0] RESP_NOMATCH = 8'h4E;
    localparam int         RESP_HDR_LEN = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SEND   = 3'd2,
        ST_ACK    = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_GAP    = 3'd5,
        ST_FINISH = 3'd6
    } resp_state_t;

endpackage

// File: rtl/md5_resp_tx.sv
// Serializes a search result as a framed packet: status, pos[15:8], pos[7:0],
// optional matched characters, then an XOR checksum of every preceding byte.
module md5_resp_tx
    import md5_proto_pkg::*;
#(
    parameter int MATCH_LEN = 19,
    parameter int ACK_WAIT  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        resp_start,
    input  logic        resp_match,
    input  logic [15:0] resp_byte_pos,
    input  logic [7:0]  resp_match_char,
    output logic        resp_match_char_next,
    input  logic        txd_busy,
    output logic        txd_start,
    output logic [7:0]  txd_data,
    output logic        resp_busy,
    output logic        resp_done,
    output logic [2:0]  state_dbg
);

    // Byte handshake: txd_start is a one-cycle request issued only while
    // txd_busy is low; txd_data stays fixed until txd_busy falls again (or
    // never rises within ACK_WAIT cycles, meaning the byte was taken at once).

    localparam int ACK_W = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_WAIT - 1);

    resp_state_t      state;
    logic             match_q;
    logic [15:0]      pos_q;
    logic [7:0]       checksum;
    logic [8:0]       idx;
    logic [ACK_W-1:0] ack_cnt;
    logic             sent_char;

    logic [8:0]       last_idx;
    logic [7:0]       next_byte;
    logic             next_is_char;

    assign state_dbg = state;
    assign last_idx  = match_q ? 9'(MATCH_LEN + RESP_HDR_LEN) : 9'(RESP_HDR_LEN);

    always_comb begin
        next_byte    = checksum;
        next_is_char = 1'b0;
        if (idx == 9'd0) begin
            next_byte = match_q ? RESP_MATCH : RESP_NOMATCH;
        end else if (idx == 9'd1) begin
            next_byte = pos_q[15:8];
        end else if (idx == 9'd2) begin
            next_byte = pos_q[7:0];
        end else if (idx != last_idx) begin
            next_byte    = resp_match_char;
            next_is_char = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= ST_IDLE;
            match_q              <= 1'b0;
            pos_q                <= 16'h0000;
            checksum             <= 8'h00;
            idx                  <= 9'd0;
            ack_cnt              <= '0;
            sent_char            <= 1'b0;
            txd_start            <= 1'b0;
            txd_data             <= 8'h00;
            resp_match_char_next <= 1'b0;
            resp_busy            <= 1'b0;
            resp_done            <= 1'b0;
        end else begin
            txd_start            <= 1'b0;
            resp_match_char_next <= 1'b0;
            resp_done            <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (resp_start) begin
                        match_q   <= resp_match;
                        pos_q     <= resp_byte_pos;
                        checksum  <= 8'h00;
                        idx       <= 9'd0;
                        resp_busy <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    txd_data  <= next_byte;
                    checksum  <= checksum ^ next_byte;
                    sent_char <= next_is_char;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (!txd_busy) begin
                        txd_start <= 1'b1;
                        ack_cnt   <= '0;
                        state     <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (txd_busy || ack_cnt == ACK_LAST) begin
                        state <= ST_DRAIN;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!txd_busy) begin
                        idx <= idx + 9'd1;
                        if (sent_char) begin
                            resp_match_char_next <= 1'b1;
                            state                <= ST_GAP;
                        end else if (idx == last_idx) begin
                            state <= ST_FINISH;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                // Matcher needs one cycle after the advance strobe to present the next char.
                ST_GAP: begin
                    state <= ST_LOAD;
                end
                ST_FINISH: begin
                    resp_done <= 1'b1;
                    resp_busy <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
